// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM state encoding,
// reset fetch address and the {pc, inst, adef} bundle handed to ID.
// Optional macro FETCH_ADEF_EN adds the ERR state for misaligned fetch PCs.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3
`ifdef FETCH_ADEF_EN
        ,
        ST_ERR  = 3'd4
`endif
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fetch_bundle_t;

    // Sequential fetch address; 32-bit add wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction bus plus the valid/ready bundle port towards ID.
// master = fetch_ctrl side, slave = memory / ID side.
interface fetch_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adef;

    modport master (
        output inst_req, inst_addr, out_valid, out_pc, out_inst, out_adef,
        input  inst_addr_ok, inst_data_ok, inst_rdata, out_ready
    );

    modport slave (
        input  inst_req, inst_addr, out_valid, out_pc, out_inst, out_adef,
        output inst_addr_ok, inst_data_ok, inst_rdata, out_ready
    );

endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready output register for fetch bundles.
// Priority: flush > write > pop; a write in the same cycle as a pop keeps
// the entry valid with the new bundle.
module fetch_out_buf
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  fetch_bundle_t wr_data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output fetch_bundle_t data_o
);

    logic          valid_q, valid_d;
    fetch_bundle_t data_q,  data_d;

    // Next entry state from flush / write / pop requests.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (wr_en_i) begin
            valid_d = 1'b1;
            data_d  = wr_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register; payload is cleared too so ID sees zeros out of reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding word fetch, redirect from
// exception / ertn / branch, stale-response dropping, one-entry output buffer.
// Optional macro FETCH_ADEF_EN: misaligned PCs produce an adef bundle and
// park the FSM in ERR until the next redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [31:0] eentry,
    input  logic [31:0] era,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    fetch_if.master     bus
);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          buf_free;
    logic          misalign;
    logic          req_ok;
    logic          accept;
    logic          buf_wr;
    fetch_bundle_t buf_wr_data;
    logic          buf_valid;
    fetch_bundle_t buf_data;

    // Redirect arbitration: exception beats ertn beats branch.
    always_comb begin
        redirect = excp_flush | ertn_flush | br_taken;
        if (excp_flush)      redirect_pc = eentry;
        else if (ertn_flush) redirect_pc = era;
        else                 redirect_pc = br_target;
    end

    // A same-cycle pop frees the buffer for a new request.
    assign buf_free = !buf_valid || bus.out_ready;

`ifdef FETCH_ADEF_EN
    assign misalign      = (pc_q[1:0] != 2'b00);
    assign bus.inst_addr = pc_q;
`else
    assign misalign      = 1'b0;
    assign bus.inst_addr = {pc_q[31:2], 2'b00};
`endif

    assign req_ok       = (state_q == ST_REQ) && buf_free && !misalign;
    assign bus.inst_req = req_ok;
    assign accept       = req_ok && bus.inst_addr_ok;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: request, wait for data, or drain a stale response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (redirect)       state_d = accept ? ST_DROP : ST_REQ;
                else if (accept)    state_d = ST_WAIT;
`ifdef FETCH_ADEF_EN
                else if (misalign && buf_free) state_d = ST_ERR;
`endif
            end
            ST_WAIT: begin
                if (bus.inst_data_ok) state_d = ST_REQ;
                else if (redirect)    state_d = ST_DROP;
            end
            ST_DROP: begin
                if (bus.inst_data_ok) state_d = ST_REQ;
            end
`ifdef FETCH_ADEF_EN
            ST_ERR: begin
                if (redirect) state_d = ST_REQ;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: buffer writes and PC bookkeeping; redirect wins over both.
    always_comb begin
        buf_wr           = 1'b0;
        buf_wr_data.pc   = req_pc_q;
        buf_wr_data.inst = bus.inst_rdata;
        buf_wr_data.adef = 1'b0;
        pc_d             = pc_q;
        req_pc_d         = req_pc_q;

        if (state_q == ST_WAIT && bus.inst_data_ok && !redirect) buf_wr = 1'b1;
`ifdef FETCH_ADEF_EN
        if (state_q == ST_REQ && misalign && buf_free && !redirect) begin
            buf_wr           = 1'b1;
            buf_wr_data.pc   = pc_q;
            buf_wr_data.inst = 32'h0;
            buf_wr_data.adef = 1'b1;
        end
`endif
        if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_inc(pc_q);
        end
        if (redirect) pc_d = redirect_pc;
    end

    // PC and in-flight request address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_out_buf u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (redirect),
        .wr_en_i   (buf_wr),
        .wr_data_i (buf_wr_data),
        .ready_i   (bus.out_ready),
        .valid_o   (buf_valid),
        .data_o    (buf_data)
    );

    // Without FETCH_ADEF_EN every write carries adef=0, so out_adef stays 0.
    assign bus.out_valid = buf_valid;
    assign bus.out_pc    = buf_data.pc;
    assign bus.out_inst  = buf_data.inst;
    assign bus.out_adef  = buf_data.adef;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: the bench plays memory and ID cycle by cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush, ertn_flush, br_taken;
    logic [31:0] eentry, era, br_target;

    int n_total = 0;
    int n_bad   = 0;

    fetch_if bus();

    fetch_ctrl #(.RESET_PC(32'h1C00_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .excp_flush (excp_flush),
        .ertn_flush (ertn_flush),
        .eentry     (eentry),
        .era        (era),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and drop all single-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        excp_flush       = 1'b0;
        ertn_flush       = 1'b0;
        br_taken         = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        #1;
    endtask

    // One zero-wait fetch from REQ: accept now, data next cycle, bundle after.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] rdata);
        check("req", bus.inst_req, 1);
        check("addr", bus.inst_addr, addr);
        bus.inst_addr_ok = 1'b1;
        tick();
        check("wait_no_req", bus.inst_req, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = rdata;
        tick();
        check("bundle_valid", bus.out_valid, 1);
        check("bundle_pc", bus.out_pc, addr);
        check("bundle_inst", bus.out_inst, rdata);
        check("bundle_adef", bus.out_adef, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        excp_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
        eentry = '0; era = '0; br_target = '0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        bus.out_ready    = 1'b1;

        // Reset values
        #12;
        check("rst_req", bus.inst_req, 0);
        check("rst_addr", bus.inst_addr, 32'h1C00_0000);
        check("rst_valid", bus.out_valid, 0);
        check("rst_pc", bus.out_pc, 0);
        check("rst_inst", bus.out_inst, 0);
        check("rst_adef", bus.out_adef, 0);

        // Release: IDLE for one cycle, then REQ
        tick();
        reset = 1'b0;
        #1;
        check("idle_no_req", bus.inst_req, 0);
        tick();

        // Streaming at one bundle per 2 cycles
        fetch_one(32'h1C00_0000, 32'hA000_0000);
        fetch_one(32'h1C00_0004, 32'hA000_0004);
        fetch_one(32'h1C00_0008, 32'hA000_0008);

        // Branch while in WAIT; stale data 3 cycles later is dropped
        check("s2_addr", bus.inst_addr, 32'h1C00_000C);
        bus.inst_addr_ok = 1'b1;
        tick();
        check("s2_popped", bus.out_valid, 0);
        br_taken  = 1'b1;
        br_target = 32'h1C00_0100;
        tick();
        check("s2_drop_req", bus.inst_req, 0);
        tick();
        tick();
        check("s2_drop_req2", bus.inst_req, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        tick();
        check("s2_stale_dropped", bus.out_valid, 0);
        fetch_one(32'h1C00_0100, 32'h1111_0000);

        // Exception and branch together: exception wins, buffer flushed
        bus.out_ready = 1'b0;
        #1;
        check("s3_full_no_req", bus.inst_req, 0);
        excp_flush = 1'b1;
        eentry     = 32'h1C00_8000;
        br_taken   = 1'b1;
        br_target  = 32'h1C00_0200;
        tick();
        check("s3_flushed", bus.out_valid, 0);
        check("s3_req", bus.inst_req, 1);
        check("s3_addr", bus.inst_addr, 32'h1C00_8000);
        bus.out_ready = 1'b1;
        #1;
        fetch_one(32'h1C00_8000, 32'h2222_0000);

        // Back-pressure: bundle held stable, no request
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("s4_no_req", bus.inst_req, 0);
            check("s4_valid", bus.out_valid, 1);
            check("s4_pc", bus.out_pc, 32'h1C00_8000);
            check("s4_inst", bus.out_inst, 32'h2222_0000);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        fetch_one(32'h1C00_8004, 32'h3333_0000);

        // Redirect coincident with data in WAIT: no bundle, no DROP
        check("s5_addr", bus.inst_addr, 32'h1C00_8008);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h4444_0000;
        br_taken         = 1'b1;
        br_target        = 32'h1C00_0300;
        tick();
        check("s5_no_bundle", bus.out_valid, 0);
        check("s5_req", bus.inst_req, 1);
        check("s5_addr_tgt", bus.inst_addr, 32'h1C00_0300);
        fetch_one(32'h1C00_0300, 32'h5555_0000);

        // PC wrap at the top of the address space
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFC;
        tick();
        check("s6_flushed", bus.out_valid, 0);
        fetch_one(32'hFFFF_FFFC, 32'h6666_0000);
        check("s6_wrap_req", bus.inst_req, 1);
        check("s6_wrap_addr", bus.inst_addr, 32'h0000_0000);

        // Redirect in REQ with addr_ok: response must be drained in DROP
        bus.inst_addr_ok = 1'b1;
        br_taken         = 1'b1;
        br_target        = 32'h1C00_0400;
        tick();
        check("s7_drop_req", bus.inst_req, 0);
        check("s7_flushed", bus.out_valid, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h7777_0000;
        tick();
        check("s7_no_bundle", bus.out_valid, 0);
        check("s7_req", bus.inst_req, 1);
        check("s7_addr", bus.inst_addr, 32'h1C00_0400);

        // ertn beats branch
        ertn_flush = 1'b1;
        era        = 32'h1C00_0500;
        br_taken   = 1'b1;
        br_target  = 32'h1C00_0600;
        tick();
        check("s8_addr", bus.inst_addr, 32'h1C00_0500);

        // Reset mid-transaction aborts immediately
        bus.inst_addr_ok = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("s9_req", bus.inst_req, 0);
        check("s9_addr", bus.inst_addr, 32'h1C00_0000);
        check("s9_valid", bus.out_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        check("s9_idle", bus.inst_req, 0);
        tick();
        fetch_one(32'h1C00_0000, 32'h8888_0000);

`ifdef FETCH_ADEF_EN
        // Misaligned ertn target: adef bundle, parked in ERR until exception
        ertn_flush = 1'b1;
        era        = 32'h1C00_0002;
        tick();
        check("adef_no_req", bus.inst_req, 0);
        tick();
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("adef_err_no_req", bus.inst_req, 0);
            check("adef_valid", bus.out_valid, 1);
            check("adef_pc", bus.out_pc, 32'h1C00_0002);
            check("adef_inst", bus.out_inst, 0);
            check("adef_flag", bus.out_adef, 1);
            tick();
        end
        excp_flush = 1'b1;
        eentry     = 32'h1C00_8000;
        tick();
        check("adef_flushed", bus.out_valid, 0);
        check("adef_exit_req", bus.inst_req, 1);
        check("adef_exit_addr", bus.inst_addr, 32'h1C00_8000);
        bus.out_ready = 1'b1;
        #1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the PC redirect sources (exception, ertn, branch) and an SRAM-like instruction bus. It issues one word fetch at a time, tracks the in-flight request, and discards stale responses after a redirect. It delivers `{pc, inst}` bundles to ID through a one-entry valid/ready output buffer. This block replaces ad-hoc PC/valid handling with an explicit state machine that tolerates multi-cycle memory latency.

## Interface
- RESET_PC, 32'h1C00_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- excp_flush  in  1  exception redirect pulse, target `eentry`
- ertn_flush  in  1  ertn redirect pulse, target `era`
- eentry  in  32  exception entry address
- era  in  32  exception return address
- br_taken  in  1  branch/jump redirect pulse
- br_target  in  32  branch target
- inst_req  out  1  fetch request (read, word)
- inst_addr  out  32  fetch address
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- out_valid  out  1  bundle valid to ID
- out_ready  in  1  ID accepts bundle
- out_pc  out  32  PC of bundle
- out_inst  out  32  instruction of bundle
- out_adef  out  1  fetch-address-error flag of bundle

## Operation
- Redirect priority: excp_flush > ertn_flush > br_taken; `redirect` = OR of the three; target is the highest-priority source.
- Registers: `pc` (next fetch address), `req_pc` (address of in-flight request), state, output buffer.
- States: IDLE, REQ, WAIT, DROP, ERR (ERR only with macro).
- IDLE: entered at reset; always moves to REQ next cycle.
- REQ: `inst_req`=1 and `inst_addr`=`pc` only when the buffer is empty or popped this cycle (`out_ready`); otherwise `inst_req`=0. On `inst_addr_ok` without redirect: `req_pc`<=`pc`, `pc`<=`pc`+4, go WAIT.
- WAIT: on `inst_data_ok`, write buffer {`req_pc`, `inst_rdata`, 0}, go REQ.
- DROP: on `inst_data_ok`, discard the data and go REQ.
- Redirect handling, all states: `pc`<=target and buffer `out_valid`<=0.
  - REQ, no `inst_addr_ok`: stay REQ. `inst_addr` shows the new target next cycle. The slave samples only on `inst_addr_ok`.
  - REQ with `inst_addr_ok`: the old request is in flight, go DROP.
  - WAIT without `inst_data_ok`: go DROP.
  - WAIT with `inst_data_ok`: data discarded, go REQ.
  - DROP: stay DROP unless `inst_data_ok`, then REQ.
  - ERR: go REQ.
- Output buffer: pop when `out_valid && out_ready`. A write and a pop in the same cycle leave the buffer valid with the new data. A redirect overrides any write in the same cycle.
- Invariant: at most one request outstanding; outstanding plus buffered is at most 1 (a same-cycle pop counts as free).
- Arithmetic: `pc`+4 is 32-bit and wraps modulo 2^32.

## Timing
- Reset values: `pc`=RESET_PC, state IDLE, `inst_req`=0, `inst_addr`=RESET_PC, `out_valid`=0, `out_pc`=0, `out_inst`=0, `out_adef`=0.
- First `inst_req` appears in the first cycle after reset deasserts plus one (IDLE→REQ).
- Latency: `inst_addr_ok` in cycle N, `inst_data_ok` no earlier than N+1, `out_valid` in the cycle after `inst_data_ok`.
- Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Redirect in cycle N (not ending in DROP): `inst_req` with the target in N+1.
- Reset asserted mid-transaction aborts everything immediately. No response is expected after reset.

## Configuration
- `FETCH_ADEF_EN` defined: in REQ, if `pc[1:0]`≠0, no request is issued. When the buffer is free, write {`pc`, 32'h0, 1} and go ERR. ERR issues no requests and leaves only on a redirect.
- Undefined: no alignment check. `inst_addr`={`pc[31:2]`,2'b00}, `out_adef` is tied to 0, and ERR does not exist.

## Structure
- Package `fetch_pkg`: state enum `fetch_state_e`, `RESET_PC_DEFAULT` constant, bundle struct {pc, inst, adef}.
- Sub-module `fetch_out_buf`: one-entry valid/ready register with flush input. All control stays in `fetch_ctrl`.

## Test plan
- Reset release, memory with `inst_addr_ok` immediate and `inst_data_ok` at +1, `out_ready`=1 → bundles pc 0x1C000000, 0x1C000004, 0x1C000008 with `inst_rdata` values, one every 2 cycles.
- `br_taken` to 0x1C000100 while in WAIT, data returns 3 cycles later → old data dropped; next `inst_req` addr 0x1C000100; first bundle pc 0x1C000100.
- `excp_flush` (eentry 0x1C008000) and `br_taken` (0x1C000200) in the same cycle → next fetch 0x1C008000, buffer flushed.
- `out_ready`=0 for 5 cycles with a bundle held → `inst_req` stays 0, the bundle is stable, and fetch resumes when `out_ready` rises.
- Redirect coincident with `inst_data_ok` in WAIT → no bundle written; `inst_req` to the target the next cycle, with no DROP state.
- With `FETCH_ADEF_EN`: `ertn_flush` with era 0x1C000002 → no `inst_req`, bundle pc 0x1C000002 with `out_adef`=1, held in ERR until `excp_flush` redirects.
